// File: rtl/lbm_collision_unit.sv
`default_nettype none
// ============================================================================
// Module   : lbm_collision_unit
// Purpose  : D2Q9 BGK collision for one lattice cell (moments, divide,
//            equilibrium, relaxation) with bounce-back for barrier cells.
// Revision : 1.0 - initial release
// ============================================================================
module lbm_collision_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int FRAC_BITS     = 12,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9*DATA_WIDTH-1:0]  in_f,
  input  logic                     in_barrier,
  input  logic [ADDRESS_WIDTH-1:0] in_index,
  input  logic [FRAC_BITS+1:0]     omega,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9*DATA_WIDTH-1:0]  out_f,
  output logic [ADDRESS_WIDTH-1:0] out_index,
  output logic                     busy
);

  localparam int c_DW   = DATA_WIDTH;
  localparam int c_RHOW = DATA_WIDTH + 4;
  localparam int c_REMW = DATA_WIDTH + 5;
  localparam int c_QW   = FRAC_BITS + 1;
  localparam int c_UW   = FRAC_BITS + 2;
  localparam int c_PW   = 2*DATA_WIDTH + 2*FRAC_BITS + 8;
  localparam int c_CW   = $clog2(FRAC_BITS + 1);

  localparam logic [c_CW-1:0]        c_DIV_LAST = c_CW'(FRAC_BITS);
  localparam logic signed [c_PW-1:0] c_ONE   = c_PW'(2**FRAC_BITS);
  localparam logic signed [c_PW-1:0] c_THREE = c_PW'(3);
  localparam logic signed [c_PW-1:0] c_NINE  = c_PW'(9);
  localparam logic signed [c_PW-1:0] c_FMAX  = c_PW'(2**DATA_WIDTH - 1);
  localparam logic signed [c_PW-1:0] c_W0    = c_PW'((4 * 2**FRAC_BITS + 4) / 9);
  localparam logic signed [c_PW-1:0] c_W1    = c_PW'((2**FRAC_BITS + 4) / 9);
  localparam logic signed [c_PW-1:0] c_W2    = c_PW'((2**FRAC_BITS + 18) / 36);

  // Slot order: C0, N, NE, E, SE, S, SW, W, NW
  function automatic int f_ex(input int k);
    case (k)
      2, 3, 4: f_ex = 1;
      6, 7, 8: f_ex = -1;
      default: f_ex = 0;
    endcase
  endfunction

  function automatic int f_ey(input int k);
    case (k)
      1, 2, 8: f_ey = 1;
      4, 5, 6: f_ey = -1;
      default: f_ey = 0;
    endcase
  endfunction

  function automatic int f_opp(input int k);
    f_opp = (k == 0) ? 0 : ((k + 3) % 8) + 1;
  endfunction

  function automatic int f_wcls(input int k);
    f_wcls = (k == 0) ? 0 : ((k % 2) == 1) ? 1 : 2;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MOMENT     = 3'd1,
    S_DIVIDE     = 3'd2,
    S_EQUIL      = 3'd3,
    S_RELAX      = 3'd4,
    S_OUTPUT     = 3'd5,
    S_BOUNCE_OUT = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [9*c_DW-1:0]        r_f;
  logic [FRAC_BITS+1:0]     r_omega;
  logic [ADDRESS_WIDTH-1:0] r_index;
  logic [c_RHOW-1:0]        r_rho;
  logic [c_REMW-1:0]        r_rem_x, r_rem_y;
  logic [c_QW-1:0]          r_qx, r_qy;
  logic                     r_neg_x, r_neg_y;
  logic [c_CW-1:0]          r_cnt;
  logic [9*c_DW-1:0]        r_out_f;

  logic                     w_accept;
  logic [c_DW-1:0]          w_fi [9];
  logic [c_RHOW-1:0]        w_rho, w_jx, w_jy, w_ajx, w_ajy;
  logic                     w_ge_x, w_ge_y;
  logic [c_REMW-1:0]        w_sub_x, w_sub_y;
  logic signed [c_UW-1:0]   w_ux, w_uy;
  logic signed [c_PW-1:0]   w_ux_p, w_uy_p, w_rho_p, w_om_p, w_usq;
  logic signed [c_PW-1:0]   w_wr_cls [3];
  logic [9*c_DW-1:0]        w_bounce, w_relax;

  assign w_accept  = in_valid && in_ready;
  assign out_f     = r_out_f;
  assign out_index = r_index;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = in_barrier ? S_BOUNCE_OUT : S_MOMENT;
      end
      S_MOMENT: w_next = (w_rho == '0) ? S_EQUIL : S_DIVIDE;
      S_DIVIDE: if (r_cnt == c_DIV_LAST) w_next = S_EQUIL;
      S_EQUIL:  w_next = S_RELAX;
      S_RELAX:  w_next = S_OUTPUT;
      S_OUTPUT, S_BOUNCE_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- moments
  always_comb begin
    w_rho = '0;
    w_jx  = '0;
    w_jy  = '0;
    for (int k = 0; k < 9; k++) begin
      w_rho = w_rho + c_RHOW'(w_fi[k]);
      if (f_ex(k) > 0)      w_jx = w_jx + c_RHOW'(w_fi[k]);
      else if (f_ex(k) < 0) w_jx = w_jx - c_RHOW'(w_fi[k]);
      if (f_ey(k) > 0)      w_jy = w_jy + c_RHOW'(w_fi[k]);
      else if (f_ey(k) < 0) w_jy = w_jy - c_RHOW'(w_fi[k]);
    end
  end

  assign w_ajx = w_jx[c_RHOW-1] ? -w_jx : w_jx;
  assign w_ajy = w_jy[c_RHOW-1] ? -w_jy : w_jy;

  // One restoring step per cycle; |j| <= rho so the first bit is the integer part.
  assign w_ge_x  = r_rem_x >= c_REMW'(r_rho);
  assign w_ge_y  = r_rem_y >= c_REMW'(r_rho);
  assign w_sub_x = w_ge_x ? (r_rem_x - c_REMW'(r_rho)) : r_rem_x;
  assign w_sub_y = w_ge_y ? (r_rem_y - c_REMW'(r_rho)) : r_rem_y;

  assign w_ux = r_neg_x ? -$signed({1'b0, r_qx}) : $signed({1'b0, r_qx});
  assign w_uy = r_neg_y ? -$signed({1'b0, r_qy}) : $signed({1'b0, r_qy});

  // ------------------------------------------------------------ equilibrium
  assign w_ux_p  = c_PW'(w_ux);
  assign w_uy_p  = c_PW'(w_uy);
  assign w_rho_p = $signed(c_PW'(r_rho));
  assign w_om_p  = $signed(c_PW'(r_omega));
  assign w_usq   = ((w_ux_p * w_ux_p) >>> FRAC_BITS) + ((w_uy_p * w_uy_p) >>> FRAC_BITS);

  assign w_wr_cls[0] = (c_W0 * w_rho_p) >>> FRAC_BITS;
  assign w_wr_cls[1] = (c_W1 * w_rho_p) >>> FRAC_BITS;
  assign w_wr_cls[2] = (c_W2 * w_rho_p) >>> FRAC_BITS;

  generate
    for (genvar k = 0; k < 9; k++) begin : g_dir
      localparam logic signed [c_PW-1:0] c_EX = c_PW'(f_ex(k));
      localparam logic signed [c_PW-1:0] c_EY = c_PW'(f_ey(k));
      localparam int c_CLS = f_wcls(k);
      localparam int c_OPP = f_opp(k);

      logic signed [c_PW-1:0] w_eu, w_eu2, w_br, w_feq;
      logic signed [c_PW-1:0] w_fe, w_diff, w_adj, w_sum;
      logic signed [c_PW-1:0] r_feq;

      assign w_fi[k] = r_f[k*c_DW +: c_DW];
      assign w_bounce[k*c_DW +: c_DW] = in_f[c_OPP*c_DW +: c_DW];

      assign w_eu  = c_EX * w_ux_p + c_EY * w_uy_p;
      assign w_eu2 = (w_eu * w_eu) >>> FRAC_BITS;
      assign w_br  = c_ONE + c_THREE * w_eu + ((c_NINE * w_eu2) >>> 1)
                   - ((c_THREE * w_usq) >>> 1);
      assign w_feq = (w_wr_cls[c_CLS] * w_br) >>> FRAC_BITS;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_feq <= '0;
        else if (r_state == S_EQUIL) r_feq <= w_feq;
      end

      assign w_fe   = $signed(c_PW'(w_fi[k]));
      assign w_diff = r_feq - w_fe;
      assign w_adj  = (w_om_p * w_diff) >>> FRAC_BITS;
      assign w_sum  = w_fe + w_adj;
      assign w_relax[k*c_DW +: c_DW] = (w_sum < 0)      ? '0 :
                                       (w_sum > c_FMAX) ? '1 : w_sum[c_DW-1:0];
    end
  endgenerate

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f     <= '0;
      r_omega <= '0;
      r_index <= '0;
      r_rho   <= '0;
      r_rem_x <= '0;
      r_rem_y <= '0;
      r_qx    <= '0;
      r_qy    <= '0;
      r_neg_x <= 1'b0;
      r_neg_y <= 1'b0;
      r_cnt   <= '0;
      r_out_f <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f     <= in_f;
            r_omega <= omega;
            r_index <= in_index;
            if (in_barrier) r_out_f <= w_bounce;
          end
        end
        S_MOMENT: begin
          r_rho   <= w_rho;
          r_rem_x <= c_REMW'(w_ajx);
          r_rem_y <= c_REMW'(w_ajy);
          r_neg_x <= w_jx[c_RHOW-1];
          r_neg_y <= w_jy[c_RHOW-1];
          r_qx    <= '0;
          r_qy    <= '0;
          r_cnt   <= '0;
        end
        S_DIVIDE: begin
          r_rem_x <= w_sub_x << 1;
          r_rem_y <= w_sub_y << 1;
          r_qx    <= {r_qx[c_QW-2:0], w_ge_x};
          r_qy    <= {r_qy[c_QW-2:0], w_ge_y};
          r_cnt   <= r_cnt + c_CW'(1);
        end
        S_RELAX: r_out_f <= w_relax;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbm_collision_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbm_collision_unit
// Purpose  : Randomized self-checking bench for lbm_collision_unit against a
//            plain-arithmetic BGK / bounce-back reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbm_collision_unit;

  localparam int DW = 16;
  localparam int F  = 12;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [9*DW-1:0]   in_f;
  logic              in_barrier;
  logic [AW-1:0]     in_index;
  logic [F+1:0]      omega;
  logic              out_valid;
  logic              out_ready;
  logic [9*DW-1:0]   out_f;
  logic [AW-1:0]     out_index;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Lattice vectors for C0, N, NE, E, SE, S, SW, W, NW
  int c_ex [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  int c_ey [9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};

  lbm_collision_unit #(.DATA_WIDTH(DW), .FRAC_BITS(F), .ADDRESS_WIDTH(AW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .in_barrier(in_barrier), .in_index(in_index), .omega(omega),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint weight(input int i);
    real w;
    if (c_ex[i] == 0 && c_ey[i] == 0)      w = 4.0 / 9.0;
    else if (c_ex[i] == 0 || c_ey[i] == 0) w = 1.0 / 9.0;
    else                                   w = 1.0 / 36.0;
    return longint'($rtoi(w * real'(1 << F) + 0.5));
  endfunction

  function automatic logic [9*DW-1:0] pack9(input int c0, input int n, input int ne, input int e,
                                            input int se, input int s, input int sw, input int w,
                                            input int nw);
    int v [9];
    logic [9*DW-1:0] p;
    v = '{c0, n, ne, e, se, s, sw, w, nw};
    for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(v[k]);
    return p;
  endfunction

  function automatic logic [9*DW-1:0] rand_f(input int maxv);
    logic [9*DW-1:0] p;
    for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'($urandom_range(0, maxv));
    return p;
  endfunction

  function automatic logic [9*DW-1:0] ref_out(input logic [9*DW-1:0] f, input bit bar,
                                              input longint om);
    longint fi [9];
    longint rho, jx, jy, q, ux, uy, usq, eu, eu2, br, wr, feq, fo;
    logic [9*DW-1:0] r;
    for (int k = 0; k < 9; k++) fi[k] = longint'(f[k*DW +: DW]);
    if (bar) begin
      for (int i = 0; i < 9; i++)
        for (int j = 0; j < 9; j++)
          if (c_ex[j] == -c_ex[i] && c_ey[j] == -c_ey[i]) r[i*DW +: DW] = DW'(fi[j]);
      return r;
    end
    rho = 0; jx = 0; jy = 0;
    for (int k = 0; k < 9; k++) begin
      rho += fi[k];
      jx  += c_ex[k] * fi[k];
      jy  += c_ey[k] * fi[k];
    end
    ux = 0; uy = 0;
    if (rho != 0) begin
      q  = ((jx < 0 ? -jx : jx) << F) / rho;
      ux = (jx < 0) ? -q : q;
      q  = ((jy < 0 ? -jy : jy) << F) / rho;
      uy = (jy < 0) ? -q : q;
    end
    usq = ((ux * ux) >>> F) + ((uy * uy) >>> F);
    for (int i = 0; i < 9; i++) begin
      eu  = c_ex[i] * ux + c_ey[i] * uy;
      eu2 = (eu * eu) >>> F;
      br  = (longint'(1) << F) + 3 * eu + ((9 * eu2) >>> 1) - ((3 * usq) >>> 1);
      wr  = (weight(i) * rho) >>> F;
      feq = (wr * br) >>> F;
      fo  = fi[i] + ((om * (feq - fi[i])) >>> F);
      if (fo < 0) fo = 0;
      if (fo > (longint'(1) << DW) - 1) fo = (longint'(1) << DW) - 1;
      r[i*DW +: DW] = DW'(fo);
    end
    return r;
  endfunction

  // Accept one cell, measure latency, check result, hold for `hold` stalled cycles.
  task automatic run_cell(input string tag, input logic [9*DW-1:0] f, input bit bar,
                          input logic [AW-1:0] idx, input logic [F+1:0] om,
                          input int hold, input bit rdy_early);
    logic [9*DW-1:0] exp_f;
    longint rho;
    int lat, exp_lat;
    exp_f = ref_out(f, bar, longint'(om));
    rho = 0;
    for (int k = 0; k < 9; k++) rho += longint'(f[k*DW +: DW]);
    exp_lat = bar ? 1 : (rho == 0) ? 4 : F + 5;

    @(negedge clk);
    check_val({tag, "_in_ready"}, in_ready, 1'b1);
    in_f = f; in_barrier = bar; in_index = idx; omega = om;
    in_valid = 1'b1; out_ready = rdy_early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_f = rand_f(65535); in_barrier = $urandom_range(0, 1); omega = (F+2)'($urandom);
    in_index = AW'($urandom);

    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, lat, exp_lat);
    check_val({tag, "_out_f"}, out_f, exp_f);
    check_val({tag, "_out_index"}, out_index, idx);
    check_val({tag, "_busy"}, busy, 1'b1);

    if (!rdy_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_val({tag, "_hold_f"}, out_f, exp_f);
        check_val({tag, "_hold_idx"}, out_index, idx);
        check_val({tag, "_hold_ready"}, in_ready, 1'b0);
        check_val({tag, "_hold_valid"}, out_valid, 1'b1);
        in_valid = $urandom_range(0, 1);
        in_f = rand_f(65535); in_index = AW'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_post_ready"}, in_ready, 1'b1);
    check_val({tag, "_post_valid"}, out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_f = '0; in_barrier = 1'b0; in_index = '0;
    omega = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_out_f", out_f, '0);
    check_val("rst_out_index", out_index, '0);
    rst = 1'b0;

    run_cell("rest", pack9(1820, 455, 114, 455, 114, 455, 114, 455, 114), 1'b0, 12'h001,
             14'd4096, 0, 1'b0);
    run_cell("barrier", pack9(50, 100, 11, 7, 13, 200, 17, 9, 19), 1'b1, 12'h002,
             14'd4096, 0, 1'b0);
    run_cell("omega0", pack9(100, 100, 100, 2000, 100, 100, 100, 100, 100), 1'b0, 12'h003,
             14'd0, 0, 1'b0);
    run_cell("zero", '0, 1'b0, 12'h004, 14'd4096, 0, 1'b0);
    run_cell("bkpr", pack9(900, 300, 80, 700, 60, 200, 40, 100, 90), 1'b0, 12'h005,
             14'd6000, 10, 1'b0);
    run_cell("ne_only", pack9(0, 0, 4000, 0, 0, 0, 0, 0, 0), 1'b0, 12'h006,
             14'd8192, 1, 1'b0);

    // Reset in the middle of the divide phase.
    @(negedge clk);
    in_f = pack9(500, 400, 300, 200, 100, 50, 25, 10, 5); in_barrier = 1'b0;
    in_index = 12'h0AA; omega = 14'd4096; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", out_valid, 1'b0);
    check_val("mid_rst_f", out_f, '0);
    check_val("mid_rst_idx", out_index, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_ready", in_ready, 1'b1);
    run_cell("post_rst_bar", pack9(50, 100, 11, 7, 13, 200, 17, 9, 19), 1'b1, 12'h0BB,
             14'd4096, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [9*DW-1:0] f;
      int mode;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       f = rand_f(65535);
        1:       begin
                   f = rand_f(200);
                   f[$urandom_range(0, 8)*DW +: DW] = DW'($urandom_range(1000, 65535));
                 end
        2:       f = rand_f(3000);
        default: f = rand_f(1);
      endcase
      run_cell($sformatf("rnd%0d", t), f, (mode == 2) && ($urandom_range(0, 1) == 1),
               AW'($urandom), (F+2)'($urandom_range(0, 8192)), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
